// File: rtl/block_ram_port_arbiter.sv
// Round-robin sharing of one BRAM write port and one read port.
// Read tags ride a latency pipe so each word returns to its issuer.
module block_ram_port_arbiter #(
  parameter  int DATA_WIDTH      = 16,
  parameter  int DATA_DEPTH      = 4096,
  parameter  int REQUESTER_COUNT = 4,
  parameter  int READ_LATENCY    = 2,
  localparam int AW              = $clog2(DATA_DEPTH),
  localparam int N               = REQUESTER_COUNT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N-1:0]            write_request,
  input  logic [N*DATA_WIDTH-1:0] write_request_data,
  input  logic [N*AW-1:0]         write_request_address,
  output logic [N-1:0]            write_grant,
  input  logic [N-1:0]            read_request,
  input  logic [N*AW-1:0]         read_request_address,
  output logic [N-1:0]            read_grant,
  output logic [N-1:0]            read_response_valid,
  output logic [DATA_WIDTH-1:0]   read_response_data,
  output logic                    ram_write_enable,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  output logic [AW-1:0]           ram_write_address,
  output logic [AW-1:0]           ram_read_address,
  input  logic [DATA_WIDTH-1:0]   ram_read_data
);

  localparam int PW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [PW-1:0] next;
  } pick_t;

  function automatic pick_t rr_pick(
    input logic [N-1:0]  req,
    input logic [PW-1:0] ptr
  );
    pick_t         r;
    logic [PW-1:0] idx;
    logic          hit;
    r.grant = '0;
    r.next  = ptr;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!hit && req[idx]) begin
        hit          = 1'b1;
        r.grant[idx] = 1'b1;
        r.next       = PW'((int'(idx) + 1) % N);
      end
    end
    return r;
  endfunction

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  pick_t         wr_pick;
  pick_t         rd_pick;
  logic [N-1:0]  tag_q [READ_LATENCY];

  // Grants are combinational from requests and pointers; held off in reset.
  always_comb begin
    wr_pick     = rr_pick(write_request, wr_ptr);
    rd_pick     = rr_pick(read_request, rd_ptr);
    write_grant = reset_n ? wr_pick.grant : '0;
    read_grant  = reset_n ? rd_pick.grant : '0;
  end

  // Pointers advance past the winner; hold when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (|write_grant) wr_ptr <= wr_pick.next;
      if (|read_grant)  rd_ptr <= rd_pick.next;
    end
  end

  // Steer the granted client's address/data onto the RAM ports.
  always_comb begin
    ram_write_data    = '0;
    ram_write_address = '0;
    ram_read_address  = '0;
    for (int i = 0; i < N; i++) begin
      if (write_grant[i]) begin
        ram_write_data    = write_request_data[i*DATA_WIDTH +: DATA_WIDTH];
        ram_write_address = write_request_address[i*AW +: AW];
      end
      if (read_grant[i]) begin
        ram_read_address = read_request_address[i*AW +: AW];
      end
    end
    ram_write_enable = |write_grant;
  end

  // One-hot owner tags follow each read through the RAM latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= read_grant;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Returned word goes out only alongside its owner's valid.
  always_comb begin
    read_response_valid = reset_n ? tag_q[READ_LATENCY-1] : '0;
    read_response_data  = (|read_response_valid) ? ram_read_data : '0;
  end

endmodule
